// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_pkg
// Brief    : Shared constants and types for the spatial-array MAC cell.
// Revision : 1.0 - initial release
// ============================================================================
package sa_pkg;

   localparam int CTRL_MUX1      = 0;
   localparam int CTRL_MUX2      = 1;
   localparam int CTRL_MUX3      = 2;
   localparam int CTRL_MUX4      = 3;
   localparam int CTRL_OSEL_LO   = 4;
   localparam int CTRL_OSEL_HI   = 5;
   localparam int CTRL_WD_PUSH   = 6;
   localparam int CTRL_IN_PUSH   = 7;
   localparam int CTRL_PART_PUSH = 8;

   localparam logic [1:0] OSEL_ADDER     = 2'b00;
   localparam logic [1:0] OSEL_MULT      = 2'b01;
   localparam logic [1:0] OSEL_PARTIALS  = 2'b10;
   localparam logic [1:0] OSEL_RESULT_IN = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      RUN    = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } sa_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sa_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : sa_mod_counter
// Brief    : Wrapping pointer with enable, load and a run-time wrap limit.
// Revision : 1.0 - initial release
// ============================================================================
module sa_mod_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic [WIDTH:0]   i_limit,
   output logic [WIDTH-1:0] o_value
);

   logic [WIDTH:0] w_inc;

   assign w_inc = {1'b0, o_value} + {{WIDTH{1'b0}}, 1'b1};

   // A limit of 0 pins the pointer at 0 (no weights resident yet).
   always_ff @(posedge clk) begin
      if (rst)
         o_value <= '0;
      else if (i_load)
         o_value <= i_load_val;
      else if (i_en)
         o_value <= (w_inc >= i_limit) ? '0 : w_inc[WIDTH-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/sa_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sa_cell_sequencer
// Brief    : Per-cell program sequencer driving one MAC cell's control word.
// Revision : 1.0 - initial release
// ============================================================================
module sa_cell_sequencer
   import sa_pkg::*;
#(
   parameter int DATA_WIDTH            = 16,
   parameter int CTRL_WIDTH            = 9,
   parameter int WD_BUFFER_DEPTH       = 16,
   parameter int INPUT_BUFFER_DEPTH    = 4,
   parameter int PARTIALS_BUFFER_DEPTH = 2,
   parameter int CNT_WIDTH             = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [$clog2(WD_BUFFER_DEPTH):0]         cfg_num_weights,
   input  logic [CNT_WIDTH-1:0]                     cfg_num_inputs,
   input  logic                                     cfg_src_left,
   input  logic                                     cfg_sub,
   input  logic [DATA_WIDTH-1:0]                    in_data,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic                                     busy,
   output logic                                     done,
   output logic [CTRL_WIDTH-1:0]                    cell_ctrl,
   output logic [DATA_WIDTH-1:0]                    cell_data_in,
   output logic                                     cell_data_in_valid,
   output logic [$clog2(WD_BUFFER_DEPTH)-1:0]       cell_wd_pop_idx,
   output logic [$clog2(INPUT_BUFFER_DEPTH)-1:0]    cell_input_pop_idx,
   output logic [$clog2(PARTIALS_BUFFER_DEPTH)-1:0] cell_partials_pop_idx,
   output logic                                     cell_add_sub,
   output logic                                     cell_out_valid
);

   localparam int c_WD_W = $clog2(WD_BUFFER_DEPTH);
   localparam int c_IN_W = $clog2(INPUT_BUFFER_DEPTH);
   localparam int c_NW_W = c_WD_W + 1;
   localparam logic [c_NW_W-1:0] c_WD_LIMIT = c_NW_W'(WD_BUFFER_DEPTH);
   localparam logic [c_IN_W:0]   c_IN_LIMIT = (c_IN_W + 1)'(INPUT_BUFFER_DEPTH);

   sa_seq_state_t        r_state;
   logic [c_NW_W-1:0]    r_cfg_nw;
   logic [c_NW_W-1:0]    r_nw;
   logic [CNT_WIDTH-1:0] r_cfg_ni;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_cfg_src;
   logic [c_WD_W-1:0]    r_base;
   logic [1:0]           r_drain;
   logic                 r_s1_v;
   logic [c_IN_W-1:0]    r_s1_slot;
   logic [c_WD_W-1:0]    r_s1_widx;

   logic                 w_accept;
   logic                 w_load_acc;
   logic                 w_run_acc;
   logic                 w_start;
   logic [c_WD_W-1:0]    w_wd_ptr;
   logic [c_IN_W-1:0]    w_in_ptr;
   logic [c_WD_W-1:0]    w_reuse;
   logic [CNT_WIDTH-1:0] w_nw_last;
   logic [CNT_WIDTH-1:0] w_ni_last;

   assign w_accept   = in_valid & in_ready;
   assign w_load_acc = w_accept & (r_state == LOAD_W);
   assign w_run_acc  = w_accept & (r_state == RUN);
   assign w_start    = start & (r_state == IDLE);
   assign w_nw_last  = CNT_WIDTH'(r_cfg_nw) - CNT_WIDTH'(1);
   assign w_ni_last  = r_cfg_ni - CNT_WIDTH'(1);

   assign cell_partials_pop_idx = '0;

   sa_mod_counter #(.WIDTH(c_WD_W)) u_wd_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_load_acc),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_limit    (c_WD_LIMIT),
      .o_value    (w_wd_ptr)
   );

   sa_mod_counter #(.WIDTH(c_IN_W)) u_in_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_run_acc),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_limit    (c_IN_LIMIT),
      .o_value    (w_in_ptr)
   );

   // Reuse offset k mod nw, restarted by every accepted command.
   sa_mod_counter #(.WIDTH(c_WD_W)) u_reuse_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_run_acc),
      .i_load     (w_start),
      .i_load_val ('0),
      .i_limit    (r_nw),
      .o_value    (w_reuse)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cfg_nw     <= '0;
         r_nw         <= '0;
         r_cfg_ni     <= '0;
         r_cnt        <= '0;
         r_cfg_src    <= 1'b0;
         r_base       <= '0;
         r_drain      <= '0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cell_add_sub <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cfg_nw     <= cfg_num_weights;
                  r_cfg_ni     <= cfg_num_inputs;
                  r_cfg_src    <= cfg_src_left;
                  cell_add_sub <= cfg_sub;
                  busy         <= 1'b1;
                  r_cnt        <= '0;
                  if (cfg_num_inputs == '0) begin
                     r_state <= DONE;
                     done    <= 1'b1;
                  end else if (cfg_num_weights == '0) begin
                     r_state  <= RUN;
                     in_ready <= 1'b1;
                  end else begin
                     r_state  <= LOAD_W;
                     in_ready <= 1'b1;
                     r_base   <= w_wd_ptr;
                  end
               end
            end
            LOAD_W: begin
               if (w_accept) begin
                  if (r_cnt == w_nw_last) begin
                     r_cnt   <= '0;
                     r_nw    <= r_cfg_nw;
                     r_state <= RUN;
                  end else begin
                     r_cnt <= r_cnt + CNT_WIDTH'(1);
                  end
               end
            end
            RUN: begin
               if (w_accept) begin
                  if (r_cnt == w_ni_last) begin
                     r_state  <= DRAIN;
                     in_ready <= 1'b0;
                     r_drain  <= 2'd3;
                  end else begin
                     r_cnt <= r_cnt + CNT_WIDTH'(1);
                  end
               end
            end
            // Last beat needs three cycles to reach data_out, then one more.
            DRAIN: begin
               if (r_drain == 2'd0) begin
                  r_state <= DONE;
                  done    <= 1'b1;
               end else begin
                  r_drain <= r_drain - 2'd1;
               end
            end
            DONE: begin
               r_state      <= IDLE;
               busy         <= 1'b0;
               cell_add_sub <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

   // Beat pipeline: push cycle, compute cycle, then result valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         cell_ctrl          <= '0;
         cell_data_in       <= '0;
         cell_data_in_valid <= 1'b0;
         cell_wd_pop_idx    <= '0;
         cell_input_pop_idx <= '0;
         cell_out_valid     <= 1'b0;
         r_s1_v             <= 1'b0;
         r_s1_slot          <= '0;
         r_s1_widx          <= '0;
      end else begin
         cell_data_in_valid <= w_accept;
         if (w_accept)
            cell_data_in <= in_data;
         cell_ctrl                             <= '0;
         cell_ctrl[CTRL_WD_PUSH]               <= w_load_acc;
         cell_ctrl[CTRL_IN_PUSH]               <= w_run_acc;
         cell_ctrl[CTRL_MUX1]                  <= w_run_acc & r_cfg_src;
         cell_ctrl[CTRL_MUX2]                  <= r_s1_v;
         cell_ctrl[CTRL_OSEL_HI:CTRL_OSEL_LO]  <= OSEL_ADDER;
         r_s1_v             <= w_run_acc;
         r_s1_slot          <= w_in_ptr;
         r_s1_widx          <= r_base + w_reuse;
         cell_input_pop_idx <= r_s1_v ? r_s1_slot : '0;
         cell_wd_pop_idx    <= r_s1_v ? r_s1_widx : '0;
         cell_out_valid     <= cell_ctrl[CTRL_MUX2];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sa_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_cell_sequencer
// Brief    : Scoreboard bench for sa_cell_sequencer with a program-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_cell_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  cfg_num_weights;
   logic [15:0] cfg_num_inputs;
   logic        cfg_src_left;
   logic        cfg_sub;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic [8:0]  cell_ctrl;
   logic [15:0] cell_data_in;
   logic        cell_data_in_valid;
   logic [3:0]  cell_wd_pop_idx;
   logic [1:0]  cell_input_pop_idx;
   logic [0:0]  cell_partials_pop_idx;
   logic        cell_add_sub;
   logic        cell_out_valid;

   sa_cell_sequencer dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .cfg_num_weights       (cfg_num_weights),
      .cfg_num_inputs        (cfg_num_inputs),
      .cfg_src_left          (cfg_src_left),
      .cfg_sub               (cfg_sub),
      .in_data               (in_data),
      .in_valid              (in_valid),
      .in_ready              (in_ready),
      .busy                  (busy),
      .done                  (done),
      .cell_ctrl             (cell_ctrl),
      .cell_data_in          (cell_data_in),
      .cell_data_in_valid    (cell_data_in_valid),
      .cell_wd_pop_idx       (cell_wd_pop_idx),
      .cell_input_pop_idx    (cell_input_pop_idx),
      .cell_partials_pop_idx (cell_partials_pop_idx),
      .cell_add_sub          (cell_add_sub),
      .cell_out_valid        (cell_out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {int a; int b; int c; int cyc;} ev_t;

   ev_t wq[$];   // weight pushes: data
   ev_t pq[$];   // input pushes: data, source
   ev_t cq[$];   // computes: wd idx, input idx, sub
   ev_t oq[$];   // result-valid cycles
   ev_t dq[$];   // done cycles

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference-model state: what the cell's buffers look like
   int m_wp = 0, m_ip = 0, m_base = 0, m_nw = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         if (cell_ctrl != 9'd0)
            chk("ctrl_unused_bits", int'(cell_ctrl & 9'h13C), 0);
         if (cell_ctrl[6] || cell_ctrl[7] || cell_data_in_valid)
            chk("data_in_valid", int'(cell_data_in_valid), int'(cell_ctrl[6] | cell_ctrl[7]));
         if (cell_ctrl[6]) begin
            if (wq.size() == 0) unexpected("weight_push");
            else begin
               e = wq.pop_front();
               chk("wpush_data", int'(cell_data_in), e.a);
               chk("wpush_cycle", cyc, e.cyc);
            end
         end
         if (cell_ctrl[7]) begin
            if (pq.size() == 0) unexpected("input_push");
            else begin
               e = pq.pop_front();
               chk("ipush_data", int'(cell_data_in), e.a);
               chk("ipush_src", int'(cell_ctrl[0]), e.b);
               chk("ipush_cycle", cyc, e.cyc);
            end
         end
         if (cell_ctrl[1]) begin
            if (cq.size() == 0) unexpected("compute");
            else begin
               e = cq.pop_front();
               chk("wd_pop_idx", int'(cell_wd_pop_idx), e.a);
               chk("input_pop_idx", int'(cell_input_pop_idx), e.b);
               chk("add_sub", int'(cell_add_sub), e.c);
               chk("partials_idx", int'(cell_partials_pop_idx), 0);
               chk("compute_cycle", cyc, e.cyc);
            end
         end
         if (cell_out_valid) begin
            if (oq.size() == 0) unexpected("out_valid");
            else begin
               e = oq.pop_front();
               chk("out_valid_cycle", cyc, e.cyc);
            end
         end
         if (done) begin
            if (dq.size() == 0) unexpected("done");
            else begin
               e = dq.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("busy_at_done", int'(busy), 1);
            end
         end
      end
   end

   task automatic send(input int d, output int a);
      bit acc = 1'b0;
      a = 0;
      in_valid = 1'b1;
      in_data  = d[15:0];
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         a   = cyc;
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) unexpected("accept_timeout");
   endtask

   task automatic check_idle();
      chk("queues_drained", wq.size() + pq.size() + cq.size() + oq.size() + dq.size(), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_in_ready", int'(in_ready), 0);
      chk("idle_add_sub", int'(cell_add_sub), 0);
   endtask

   // stall: 0 none, 1 alternate idle cycle, 2 random idle cycles
   task automatic run_prog(input int nw, input int ni, input bit src, input bit sub,
                           input int stall, input bit fixed, input bit busy_start,
                           input int abort_k);
      int a, d, n;
      ev_t e;
      cfg_num_weights = nw[4:0];
      cfg_num_inputs  = ni[15:0];
      cfg_src_left    = src;
      cfg_sub         = sub;
      start = 1'b1;
      n = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (ni == 0) begin
         e = '{0, 0, 0, n + 1}; dq.push_back(e);
         repeat (4) @(posedge clk); #1;
         check_idle();
         return;
      end
      if (nw > 0) begin
         m_base = m_wp;
         for (int i = 0; i < nw; i++) begin
            d = fixed ? i + 1 : int'($urandom_range(0, 65535));
            send(d, a);
            e = '{d, 0, 0, a + 1}; wq.push_back(e);
            m_wp = (m_wp + 1) % 16;
         end
         m_nw = nw;
      end
      for (int k = 0; k < ni; k++) begin
         if (k == abort_k) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort_outputs_zero",
                int'({busy, done, in_ready, cell_ctrl, cell_data_in_valid, cell_wd_pop_idx,
                      cell_input_pop_idx, cell_out_valid, cell_add_sub}), 0);
            chk("abort_data_zero", int'(cell_data_in), 0);
            wq.delete(); pq.delete(); cq.delete(); oq.delete(); dq.delete();
            m_wp = 0; m_ip = 0; m_base = 0; m_nw = 0;
            repeat (3) @(posedge clk); #1;
            check_idle();
            return;
         end
         if (busy_start && k == 2) begin
            start           = 1'b1;
            cfg_num_inputs  = 16'd0;
            cfg_num_weights = 5'd7;
            cfg_src_left    = ~src;
            cfg_sub         = ~sub;
         end
         d = fixed ? 1 : int'($urandom_range(0, 65535));
         send(d, a);
         start = 1'b0;
         e = '{d, int'(src), 0, a + 1}; pq.push_back(e);
         e = '{(m_nw == 0) ? m_base : (m_base + k % m_nw) % 16, m_ip, int'(sub), a + 2};
         cq.push_back(e);
         e = '{0, 0, 0, a + 3}; oq.push_back(e);
         m_ip = (m_ip + 1) % 4;
         if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
            @(posedge clk); #1;
         end
      end
      e = '{0, 0, 0, a + 5}; dq.push_back(e);
      repeat (10) @(posedge clk); #1;
      check_idle();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      cfg_num_weights = '0; cfg_num_inputs = '0; cfg_src_left = 1'b0; cfg_sub = 1'b0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_ctrl", int'(cell_ctrl), 0);
      chk("reset_flags", int'({busy, done, in_ready, cell_data_in_valid, cell_out_valid,
                               cell_add_sub}), 0);
      chk("reset_idx", int'({cell_wd_pop_idx, cell_input_pop_idx, cell_partials_pop_idx}), 0);
      chk("reset_data", int'(cell_data_in), 0);

      run_prog(4, 4, 1'b0, 1'b0, 0, 1'b1, 1'b0, -1);   // basic
      run_prog(2, 5, 1'b0, 1'b1, 0, 1'b0, 1'b0, -1);   // weight reuse
      run_prog(3, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, -1);   // load 3 weights
      run_prog(0, 6, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);   // resident weights, input wrap
      run_prog(3, 4, 1'b1, 1'b1, 1, 1'b0, 1'b0, -1);   // alternating stalls
      run_prog(5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);   // zero inputs
      run_prog(2, 5, 1'b0, 1'b1, 0, 1'b0, 1'b1, -1);   // start while busy
      run_prog(4, 6, 1'b1, 1'b0, 0, 1'b0, 1'b0, 3);    // reset mid-run
      run_prog(3, 4, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);   // fresh program from slot 0
      run_prog(16, 18, 1'b1, 1'b1, 2, 1'b0, 1'b0, -1); // full weight set, wrap
      for (int r = 0; r < 8; r++)
         run_prog(int'($urandom_range(0, 16)), int'($urandom_range(0, 20)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sa_cell_sequencer.md
# sa_cell_sequencer

Per-cell program sequencer for the spatial-array MAC cell. Accepts a start command with a small configuration, then streams a weight set and an input stream into one cell, and drives that cell's 9-bit control word, pop indices, `add_sub` and `data_in_valid` cycle by cycle. The cell computes `input × weight ± result_in` per beat. The sequencer mirrors the cell's internal push pointers, so the pop indices always address the most recently written slots. It sits between the array-level controller and a single cell column head.

## Interface
- `DATA_WIDTH`, 16, beat width.
- `CTRL_WIDTH`, 9, cell control word width.
- `WD_BUFFER_DEPTH`, 16, cell weight buffer depth.
- `INPUT_BUFFER_DEPTH`, 4, cell input buffer depth.
- `PARTIALS_BUFFER_DEPTH`, 2, cell partials buffer depth.
- `CNT_WIDTH`, 16, input-count width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `cfg_num_weights`  in  $clog2(WD_BUFFER_DEPTH)+1  number of weights to load; 0 reuses the resident weights.
- `cfg_num_inputs`  in  CNT_WIDTH  number of input beats.
- `cfg_src_left`  in  1  input source: 1 selects `left_in`, 0 selects `data_in`.
- `cfg_sub`  in  1  drives `add_sub` for the whole program.
- `in_data`  in  DATA_WIDTH  stream beat.
- `in_valid`  in  1  stream valid.
- `in_ready`  out  1  stream ready.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at program end.
- `cell_ctrl`  out  CTRL_WIDTH  cell control word.
- `cell_data_in`  out  DATA_WIDTH  registered beat.
- `cell_data_in_valid`  out  1  registered beat valid.
- `cell_wd_pop_idx`  out  $clog2(WD_BUFFER_DEPTH)  weight buffer pop index.
- `cell_input_pop_idx`  out  $clog2(INPUT_BUFFER_DEPTH)  input buffer pop index.
- `cell_partials_pop_idx`  out  $clog2(PARTIALS_BUFFER_DEPTH)  partials buffer pop index; held at 0.
- `cell_add_sub`  out  1  add/subtract select.
- `cell_out_valid`  out  1  high exactly in the cycles where cell `data_out` holds a result.

## Operation
- **Ctrl bit map.**
  - [0] input-buffer source, 1 = left.
  - [1] multiplier operand B, 1 = weight buffer.
  - [2] partials source.
  - [3] adder operand B, 1 = partials, 0 = `result_in`.
  - [5:4] output select, 00 = adder output.
  - [6] weight push.
  - [7] input push.
  - [8] partials push.
- **IDLE.** `in_ready` = 0. On `start`, latch all `cfg_*`, then:
  - if `cfg_num_inputs` = 0, go to DONE;
  - else if `cfg_num_weights` = 0, go to RUN;
  - else go to LOAD_W.
- **LOAD_W.** `in_ready` = 1. Each accepted beat registers `cell_data_in`, sets `cell_data_in_valid` = 1 and ctrl[6] = 1 for one cycle, and increments the weight push pointer modulo WD_BUFFER_DEPTH. After `cfg_num_weights` beats, go to RUN and latch `nw` = `cfg_num_weights`.
- **RUN.** `in_ready` = 1. An accepted beat gives a push cycle, then a compute cycle.
  - Push cycle: ctrl[7] = 1, ctrl[0] = `cfg_src_left`, `cell_data_in_valid` = 1. The input push pointer advances modulo INPUT_BUFFER_DEPTH.
  - Compute cycle: `cell_input_pop_idx` = the slot just written, `cell_wd_pop_idx` = base + (k mod `nw`), ctrl[1] = 1, ctrl[3] = 0, ctrl[5:4] = 00. Here k is the beat number and base is the weight pointer value at the start of LOAD_W.
  - Push and compute cycles of consecutive beats overlap, so back-to-back beats are accepted every cycle.
  - After `cfg_num_inputs` beats, go to DRAIN.
- **DRAIN.** Wait until the last `cell_out_valid` has been issued, then go to DONE.
- **DONE.** Pulse `done` for one cycle, then go to IDLE.
- `start` while busy is ignored. `in_valid` outside LOAD_W/RUN is ignored.
- All unused ctrl bits are 0. `cell_add_sub` = latched `cfg_sub` while busy, 0 otherwise.

## Timing
- **Reset values.** All outputs 0; state IDLE; all pointers and counters 0. `rst` mid-program aborts immediately. The cell must be reset in the same cycle so the mirrored pointers stay aligned.
- **Latency.** For a beat accepted at edge E:
  - push ctrl is visible in cycle E+1;
  - compute ctrl in E+2;
  - `cell_out_valid` in E+3, aligned with cell `data_out`.
- **Program end.** `done` asserts 2 cycles after the last `cell_out_valid`.
- **Wrap-around.** Weight index wraps modulo WD_BUFFER_DEPTH. Weight reuse wraps at `nw`.
- **Buffer safety.** The input buffer never overflows, because each slot is consumed one cycle after its push.

## Structure
- Shared package `sa_pkg`:
  - ctrl bit position constants (`CTRL_MUX1` … `CTRL_PART_PUSH`);
  - output-select encodings;
  - state enum `sa_seq_state_t` {IDLE, LOAD_W, RUN, DRAIN, DONE}.
- One sub-module is natural: `sa_mod_counter` (parameterised wrapping pointer with enable and load), instantiated for the weight, input and reuse pointers.

## Test plan
- **Basic program.** `cfg_num_weights`=4, `cfg_num_inputs`=4, `cfg_src_left`=0, weights {1,2,3,4}, inputs {1,1,1,1} -> 4 weight pushes at wd slots 0–3, then `cell_out_valid` on 4 consecutive cycles with `wd_pop_idx` 0,1,2,3.
- **Weight reuse.** `cfg_num_weights`=2, `cfg_num_inputs`=5 -> `wd_pop_idx` sequence 0,1,0,1,0; `done` 2 cycles after the fifth `cell_out_valid`.
- **Resident weights and input wrap.** `cfg_num_weights`=0 after a prior load of 3 weights, with 6 inputs -> no ctrl[6] pulse; `input_pop_idx` runs 0,1,2,3,0,1.
- **Stalls.** `in_valid` toggling 1,0,1,0 -> ctrl[7] pulses only on accepted beats; `cell_out_valid` count equals `cfg_num_inputs`.
- **Zero inputs and busy start.** `cfg_num_inputs`=0 -> `done` in the cycle after `start`, with no cell writes. A `start` issued while busy has no effect.
- **Reset mid-program.** `rst` during RUN -> next cycle all outputs 0 and IDLE; a fresh program afterwards addresses slot 0.
